seven_segment_scanner: RTL

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It holds a packed BCD word, selects one digit per scan slot, feeds that digit through a single shared `seven_segment` decoder, and drives the active-low digit enables. A blanking guard between slots prevents ghosting. New values are committed only at frame boundaries, so the display never tears.

---
 rtl/seven_segment_scanner_pkg.sv | 12 +
 rtl/seven_segment.sv | 27 ++
 rtl/seven_segment_scanner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are abcdefg with seg[6] = a; segment and digit drives are active-low.
package seven_segment_scanner_pkg;

   typedef enum logic {
      GUARD = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_segment.sv
// BCD to common-anode seven-segment decoder (abcdefg, active-low).
// Non-decimal codes 10..15 decode to a blank digit.
module seven_segment
   import seven_segment_scanner_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = 7'b0000001;
         4'd1: seg = 7'b1001111;
         4'd2: seg = 7'b0010010;
         4'd3: seg = 7'b0000110;
         4'd4: seg = 7'b1001100;
         4'd5: seg = 7'b0100100;
         4'd6: seg = 7'b0100000;
         4'd7: seg = 7'b0001111;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a common-anode display with guard blanking and frame-aligned commit.
// Optional macro SEVSEG_SCANNER_LZ_BLANK_EN enables leading-zero suppression.
module seven_segment_scanner
   import seven_segment_scanner_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   bcd_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      load,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_done,
   output logic                      pending
);

   localparam int CNT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   scan_state_t               state;
   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic [4*NUM_DIGITS-1:0]   pend_bcd;
   logic [NUM_DIGITS-1:0]     pend_dp;
   logic [4*NUM_DIGITS-1:0]   act_bcd;
   logic [NUM_DIGITS-1:0]     act_dp;
   logic [3:0]                nibble;
   logic [6:0]                dec_seg;
   logic [6:0]                show_seg;
   logic                      wrap;

   assign nibble = act_bcd[{idx, 2'b00} +: 4];
   assign wrap   = (state == SHOW) && (cnt == SLOT_LAST) && (idx == IDX_LAST);

   seven_segment u_dec (
      .digit (nibble),
      .seg   (dec_seg)
   );

`ifdef SEVSEG_SCANNER_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  zero_above;

   // Digit k is blank when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above  = zero_above & (act_bcd[4*k +: 4] == 4'd0);
         lz_blank[k] = zero_above;
      end
   end

   assign show_seg = lz_blank[idx] ? SEG_BLANK : dec_seg;
`else
   assign show_seg = dec_seg;
`endif

   // Guard re-entry preloads cnt to 1 so the post-reset guard (cnt = 0) spans one extra edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= GUARD;
         cnt        <= '0;
         idx        <= '0;
         pend_bcd   <= '0;
         pend_dp    <= '0;
         act_bcd    <= '0;
         act_dp     <= '0;
         pending    <= 1'b0;
         an         <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (load) begin
            pend_bcd <= bcd_in;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
         end else if (wrap) begin
            pending  <= 1'b0;
         end

         case (state)
            GUARD: begin
               if (cnt == GUARD_END) begin
                  state <= SHOW;
                  cnt   <= '0;
                  an    <= ~(NUM_DIGITS'(1) << idx);
                  seg   <= show_seg;
                  dp    <= ~act_dp[idx];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SLOT_LAST) begin
                  state <= GUARD;
                  cnt   <= CNT_W'(1);
                  an    <= '1;
                  seg   <= SEG_BLANK;
                  dp    <= 1'b1;
                  if (idx == IDX_LAST) begin
                     idx        <= '0;
                     frame_done <= 1'b1;
                     if (pending) begin
                        act_bcd <= pend_bcd;
                        act_dp  <= pend_dp;
                     end
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= GUARD;
         endcase
      end
   end

endmodule
